// File: rtl/pfengine_np_if.sv
// Handshake bundle for the prefetch engine: stride-op input channel and per-pipe DC/L2 request channels.
// A beat moves when valid is high and retry is low; the sender must hold valid and its payload while retry is high.
interface pfengine_np_if #(
    parameter int NPIPES   = 2,
    parameter int LINE_W   = 26,
    parameter int STRIDE_W = 8
);
    logic                       pfgtopfe_op_valid;
    logic                       pfgtopfe_op_retry;
    logic [LINE_W-1:0]          pfgtopfe_op_base;
    logic [STRIDE_W-1:0]        pfgtopfe_op_stride;
    logic [3:0]                 pfgtopfe_op_count;
    logic                       pfgtopfe_op_l2;
    logic [NPIPES-1:0]          pftodc_req_valid;
    logic [NPIPES-1:0]          pftodc_req_retry;
    logic [NPIPES*LINE_W-1:0]   pftodc_req_addr;
    logic [NPIPES-1:0]          pftol2_req_valid;
    logic [NPIPES-1:0]          pftol2_req_retry;
    logic [NPIPES*LINE_W-1:0]   pftol2_req_addr;
    logic                       gen_state;

    modport master (
        output pfgtopfe_op_valid, pfgtopfe_op_base, pfgtopfe_op_stride, pfgtopfe_op_count,
               pfgtopfe_op_l2, pftodc_req_retry, pftol2_req_retry,
        input  pfgtopfe_op_retry, pftodc_req_valid, pftodc_req_addr,
               pftol2_req_valid, pftol2_req_addr, gen_state
    );

    modport slave (
        input  pfgtopfe_op_valid, pfgtopfe_op_base, pfgtopfe_op_stride, pfgtopfe_op_count,
               pfgtopfe_op_l2, pftodc_req_retry, pftol2_req_retry,
        output pfgtopfe_op_retry, pftodc_req_valid, pftodc_req_addr,
               pftol2_req_valid, pftol2_req_addr, gen_state
    );
endinterface

// File: rtl/pfengine_np.sv
// Stride prefetch engine: buffers ops in a FIFO, expands each into line requests,
// routes them by low address bits to NPIPES DC/L2 output slots, and keeps saturating statistics.
module pfengine_np #(
    parameter int NPIPES   = 2,
    parameter int DEPTH    = 4,
    parameter int LINE_W   = 26,
    parameter int STRIDE_W = 8,
    parameter int PAGE_SH  = 6,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    pfengine_np_if.slave     bus,
    output logic [CNT_W-1:0] pf_dc_issued,
    output logic [CNT_W-1:0] pf_l2_issued,
    output logic [CNT_W-1:0] pf_page_drops
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (NPIPES > 1) ? $clog2(NPIPES) : 1;
    localparam int PG_W = LINE_W - PAGE_SH;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    typedef struct packed {
        logic [LINE_W-1:0]   base;
        logic [STRIDE_W-1:0] stride;
        logic [3:0]          count;
        logic                l2;
    } op_t;

    state_t state_q, state_d;
    op_t    fifo_mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic full, empty, push, pop, issue, drop;
    op_t  head;

    logic [LINE_W-1:0]   cur_q;
    logic [PG_W-1:0]     basepg_q;
    logic [3:0]          rem_q;
    logic [STRIDE_W-1:0] stride_q;
    logic                l2_q;
    logic [PW-1:0]       pipe;
    logic                sel_valid, sel_retry;

    logic [NPIPES-1:0]             dc_valid, l2_valid, dc_load, l2_load, dc_xfer, l2_xfer;
    logic [NPIPES-1:0][LINE_W-1:0] dc_addr, l2_addr;
    logic [3:0]                    n_dc, n_l2;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = bus.pfgtopfe_op_valid && !full;
    assign head  = fifo_mem[rd_ptr[AW-1:0]];

    assign bus.pfgtopfe_op_retry = full;
    assign bus.pftodc_req_valid  = dc_valid;
    assign bus.pftol2_req_valid  = l2_valid;
    assign bus.pftodc_req_addr   = dc_addr;
    assign bus.pftol2_req_addr   = l2_addr;
    assign bus.gen_state         = state_q;

    assign pipe      = (NPIPES == 1) ? '0 : cur_q[PW-1:0];
    assign sel_valid = l2_q ? l2_valid[pipe] : dc_valid[pipe];
    assign sel_retry = l2_q ? bus.pftol2_req_retry[pipe] : bus.pftodc_req_retry[pipe];
    assign dc_xfer   = dc_valid & ~bus.pftodc_req_retry;
    assign l2_xfer   = l2_valid & ~bus.pftol2_req_retry;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // A slot that is draining this cycle can be refilled in the same cycle.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        issue   = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (rem_q == 4'd0) begin
                    state_d = IDLE;
                end else if (cur_q[LINE_W-1:PAGE_SH] != basepg_q) begin
                    drop    = 1'b1;
                    state_d = IDLE;
                end else if (!sel_valid || !sel_retry) begin
                    issue = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dc_load = '0;
        l2_load = '0;
        n_dc    = '0;
        n_l2    = '0;
        if (issue) begin
            if (l2_q) l2_load[pipe] = 1'b1;
            else      dc_load[pipe] = 1'b1;
        end
        for (int i = 0; i < NPIPES; i++) begin
            n_dc = n_dc + {3'b000, dc_xfer[i]};
            n_l2 = n_l2 + {3'b000, l2_xfer[i]};
        end
    end

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-3){1'b0}}, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= {bus.pfgtopfe_op_base, bus.pfgtopfe_op_stride,
                                               bus.pfgtopfe_op_count, bus.pfgtopfe_op_l2};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            cur_q         <= '0;
            basepg_q      <= '0;
            rem_q         <= '0;
            stride_q      <= '0;
            l2_q          <= 1'b0;
            dc_valid      <= '0;
            l2_valid      <= '0;
            dc_addr       <= '0;
            l2_addr       <= '0;
            pf_dc_issued  <= '0;
            pf_l2_issued  <= '0;
            pf_page_drops <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                cur_q    <= head.base;
                basepg_q <= head.base[LINE_W-1:PAGE_SH];
                rem_q    <= head.count;
                stride_q <= head.stride;
                l2_q     <= head.l2;
            end
            if (issue) begin
                cur_q <= cur_q + {{(LINE_W-STRIDE_W){stride_q[STRIDE_W-1]}}, stride_q};
                rem_q <= rem_q - 4'd1;
            end
            for (int p = 0; p < NPIPES; p++) begin
                if (dc_load[p]) begin
                    dc_valid[p] <= 1'b1;
                    dc_addr[p]  <= cur_q;
                end else if (dc_xfer[p]) begin
                    dc_valid[p] <= 1'b0;
                end
                if (l2_load[p]) begin
                    l2_valid[p] <= 1'b1;
                    l2_addr[p]  <= cur_q;
                end else if (l2_xfer[p]) begin
                    l2_valid[p] <= 1'b0;
                end
            end
            pf_dc_issued <= sat_add(pf_dc_issued, n_dc);
            pf_l2_issued <= sat_add(pf_l2_issued, n_l2);
            if (drop) pf_page_drops <= sat_add(pf_page_drops, rem_q);
        end
    end
endmodule
